mc_ctrl_fsm: RTL and testbench

Parametrised multicycle control unit for the MIPS-subset multicycle CPU. It decodes `Op`/`Funct` from the instruction register and sequences the datapath through fetch, decode, execute, memory and writeback steps. It drives the datapath select and enable lines. New in this generation: an optional memory ready handshake (wait states), jump support through a 2-bit `PCSrc`, a parametrised ALU-control width, and a sticky illegal-instruction trap.

---
 rtl/mc_pkg.sv | 56 +++++
 rtl/mc_alu_dec.sv | 30 +++
 rtl/mc_ctrl_fsm.sv | 178 +++++++++++++++++
 tb/tb_mc_ctrl_fsm.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// ---------------------------------------------------------------------------
// mc_pkg
// Shared definitions for the multicycle MIPS-subset control unit:
//   - state_t     : controller state encoding (also exported on state_o)
//   - OP_* / FUNCT_* : instruction field codes the controller decodes
//   - ALU_*       : 3-bit ALU operation codes driven on ALUControl[2:0]
//   - PCSRC_* / SRCB_* : datapath multiplexer select encodings
// ---------------------------------------------------------------------------
package mc_pkg;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_EXEC   = 4'd7,
        ST_ALUWB  = 4'd8,
        ST_BRANCH = 4'd9,
        ST_ADDIEX = 4'd10,
        ST_ADDIWB = 4'd11,
        ST_JUMP   = 4'd12,
        ST_TRAP   = 4'd13
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FUNCT_ADD = 6'b100000;
    localparam logic [5:0] FUNCT_SUB = 6'b100010;
    localparam logic [5:0] FUNCT_AND = 6'b100100;
    localparam logic [5:0] FUNCT_OR  = 6'b100101;
    localparam logic [5:0] FUNCT_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_SLT = 3'b111;

    localparam logic [1:0] PCSRC_ALURES = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    localparam logic [1:0] SRCB_REG   = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

endpackage

// File: rtl/mc_alu_dec.sv
// ---------------------------------------------------------------------------
// mc_alu_dec
// Combinational R-type function decoder.
//   funct_i       in  6  instr[5:0]
//   alu_ctrl_o    out 3  ALU operation for the decoded function
//   funct_valid_o out 1  function field is one the CPU implements
// Unknown functions decode to ALU_AND (all zero) with funct_valid_o low.
// ---------------------------------------------------------------------------
module mc_alu_dec
    import mc_pkg::*;
(
    input  logic [5:0] funct_i,
    output logic [2:0] alu_ctrl_o,
    output logic       funct_valid_o
);

    always_comb begin
        alu_ctrl_o    = ALU_AND;
        funct_valid_o = 1'b1;
        case (funct_i)
            FUNCT_ADD: alu_ctrl_o = ALU_ADD;
            FUNCT_SUB: alu_ctrl_o = ALU_SUB;
            FUNCT_AND: alu_ctrl_o = ALU_AND;
            FUNCT_OR:  alu_ctrl_o = ALU_OR;
            FUNCT_SLT: alu_ctrl_o = ALU_SLT;
            default:   funct_valid_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// mc_ctrl_fsm
// Multicycle control unit for the MIPS-subset CPU. Sequences the datapath
// through fetch/decode/execute/memory/writeback and drives its selects.
// Parameters:
//   ALUC_W        width of ALUControl (>=3, bits above 2 driven 0)
//   MEM_HANDSHAKE 1 = wait on mem_ready, 0 = memory always ready
// Ports:
//   clk, rst (async, active high), Op/Funct (instruction fields),
//   mem_ready (memory completes this cycle), mem_req, datapath controls,
//   PCSrc, ALUSrcB, ALUControl, illegal (sticky trap), state_o (debug).
// All outputs are Moore except IRWrite/PCWrite in FETCH, which are gated by
// the ready handshake so the PC and IR only load when the fetch completes.
// ---------------------------------------------------------------------------
module mc_ctrl_fsm
    import mc_pkg::*;
#(
    parameter int ALUC_W        = 3,
    parameter bit MEM_HANDSHAKE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [5:0]        Op,
    input  logic [5:0]        Funct,
    input  logic              mem_ready,
    output logic              mem_req,
    output logic              PCWrite,
    output logic              Branch,
    output logic              IRWrite,
    output logic              RegWrite,
    output logic              MemWrite,
    output logic              IorD,
    output logic              ALUSrcA,
    output logic              RegDst,
    output logic              MemtoReg,
    output logic [1:0]        PCSrc,
    output logic [1:0]        ALUSrcB,
    output logic [ALUC_W-1:0] ALUControl,
    output logic              illegal,
    output logic [3:0]        state_o
);

    state_t     state_q, state_d;
    logic       memReady;
    logic [2:0] functAluOp;
    logic       functValid;
    logic [2:0] aluOp;

    assign memReady = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign state_o  = state_q;

    mc_alu_dec u_alu_dec (
        .funct_i       (Funct),
        .alu_ctrl_o    (functAluOp),
        .funct_valid_o (functValid)
    );

    // State register; reset forces IDLE so every Moore output drops at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; request states hold until memory is ready, and TRAP
    // only leaves through reset.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   state_d = ST_FETCH;
            ST_FETCH:  if (memReady) state_d = ST_DECODE;
            ST_DECODE: begin
                case (Op)
                    OP_LW, OP_SW: state_d = ST_MEMADR;
                    OP_RTYPE:     state_d = ST_EXEC;
                    OP_BEQ:       state_d = ST_BRANCH;
                    OP_ADDI:      state_d = ST_ADDIEX;
                    OP_J:         state_d = ST_JUMP;
                    default:      state_d = ST_TRAP;
                endcase
            end
            ST_MEMADR: state_d = (Op == OP_LW) ? ST_MEMRD : ST_MEMWR;
            ST_MEMRD:  if (memReady) state_d = ST_MEMWB;
            ST_MEMWB:  state_d = ST_FETCH;
            ST_MEMWR:  if (memReady) state_d = ST_FETCH;
            ST_EXEC:   state_d = functValid ? ST_ALUWB : ST_TRAP;
            ST_ALUWB:  state_d = ST_FETCH;
            ST_BRANCH: state_d = ST_FETCH;
            ST_ADDIEX: state_d = ST_ADDIWB;
            ST_ADDIWB: state_d = ST_FETCH;
            ST_JUMP:   state_d = ST_FETCH;
            ST_TRAP:   state_d = ST_TRAP;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Output decode; everything defaults to 0 so only asserted controls are
    // listed per state.
    always_comb begin
        mem_req  = 1'b0;
        PCWrite  = 1'b0;
        Branch   = 1'b0;
        IRWrite  = 1'b0;
        RegWrite = 1'b0;
        MemWrite = 1'b0;
        IorD     = 1'b0;
        ALUSrcA  = 1'b0;
        RegDst   = 1'b0;
        MemtoReg = 1'b0;
        PCSrc    = PCSRC_ALURES;
        ALUSrcB  = SRCB_REG;
        aluOp    = ALU_AND;
        illegal  = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                ALUSrcB = SRCB_FOUR;
                aluOp   = ALU_ADD;
                IRWrite = memReady;
                PCWrite = memReady;
            end
            ST_DECODE: begin
                ALUSrcB = SRCB_IMMSH;
                aluOp   = ALU_ADD;
            end
            ST_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                aluOp   = ALU_ADD;
            end
            ST_MEMRD: begin
                mem_req = 1'b1;
                IorD    = 1'b1;
            end
            ST_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            ST_MEMWR: begin
                mem_req  = 1'b1;
                IorD     = 1'b1;
                MemWrite = 1'b1;
            end
            ST_EXEC: begin
                ALUSrcA = 1'b1;
                aluOp   = functAluOp;
            end
            ST_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            ST_BRANCH: begin
                ALUSrcA = 1'b1;
                aluOp   = ALU_SUB;
                Branch  = 1'b1;
                PCSrc   = PCSRC_ALUOUT;
            end
            ST_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_IMM;
                aluOp   = ALU_ADD;
            end
            ST_ADDIWB: RegWrite = 1'b1;
            ST_JUMP: begin
                PCWrite = 1'b1;
                PCSrc   = PCSRC_JUMP;
            end
            ST_TRAP:  illegal = 1'b1;
            default: ;
        endcase
    end

    // Widen the 3-bit ALU code; any extra upper bits stay zero.
    always_comb begin
        ALUControl      = '0;
        ALUControl[2:0] = aluOp;
    end

endmodule

// File: tb/tb_mc_ctrl_fsm.sv
// ---------------------------------------------------------------------------
// tb_mc_ctrl_fsm
// Self-checking bench for mc_ctrl_fsm. Each instruction is expanded into the
// list of steps it should take (with inserted wait cycles), and every cycle
// the DUT's state and control outputs are compared with the expected ones.
// A second instance with MEM_HANDSHAKE=0 checks that mem_ready is ignored.
// ---------------------------------------------------------------------------
module tb_mc_ctrl_fsm;
    import mc_pkg::*;

    typedef struct packed {
        logic       memReq;
        logic       pcWrite;
        logic       branch;
        logic       irWrite;
        logic       regWrite;
        logic       memWrite;
        logic       iorD;
        logic       aluSrcA;
        logic       regDst;
        logic       memtoReg;
        logic [1:0] pcSrc;
        logic [1:0] aluSrcB;
        logic [3:0] aluCtl;
        logic       illegal;
    } ctrl_t;

    typedef struct {
        state_t st;
        logic   rdy;
    } step_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       mem_ready;
    logic       nhReady;
    logic [5:0] Op, Funct;

    logic mem_req, PCWrite, Branch, IRWrite, RegWrite, MemWrite, IorD;
    logic ALUSrcA, RegDst, MemtoReg, illegal;
    logic [1:0] PCSrc, ALUSrcB;
    logic [3:0] ALUControl;
    logic [3:0] state_o;

    logic nhMemReq, nhPCWrite, nhBranch, nhIRWrite, nhRegWrite, nhMemWrite, nhIorD;
    logic nhALUSrcA, nhRegDst, nhMemtoReg, nhIllegal;
    logic [1:0] nhPCSrc, nhALUSrcB;
    logic [2:0] nhALUControl;
    logic [3:0] nhState;

    ctrl_t actCtrl, nhCtrl;
    step_t seq[$];
    int    checks = 0;
    int    errors = 0;

    always #5 clk = ~clk;

    mc_ctrl_fsm #(.ALUC_W(4), .MEM_HANDSHAKE(1'b1)) dut (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .mem_ready(mem_ready),
        .mem_req(mem_req), .PCWrite(PCWrite), .Branch(Branch), .IRWrite(IRWrite),
        .RegWrite(RegWrite), .MemWrite(MemWrite), .IorD(IorD), .ALUSrcA(ALUSrcA),
        .RegDst(RegDst), .MemtoReg(MemtoReg), .PCSrc(PCSrc), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .illegal(illegal), .state_o(state_o)
    );

    mc_ctrl_fsm #(.ALUC_W(3), .MEM_HANDSHAKE(1'b0)) dutNh (
        .clk(clk), .rst(rst), .Op(Op), .Funct(Funct), .mem_ready(nhReady),
        .mem_req(nhMemReq), .PCWrite(nhPCWrite), .Branch(nhBranch), .IRWrite(nhIRWrite),
        .RegWrite(nhRegWrite), .MemWrite(nhMemWrite), .IorD(nhIorD), .ALUSrcA(nhALUSrcA),
        .RegDst(nhRegDst), .MemtoReg(nhMemtoReg), .PCSrc(nhPCSrc), .ALUSrcB(nhALUSrcB),
        .ALUControl(nhALUControl), .illegal(nhIllegal), .state_o(nhState)
    );

    // Gather each instance's outputs into one comparable vector.
    always_comb begin
        actCtrl = '{mem_req, PCWrite, Branch, IRWrite, RegWrite, MemWrite, IorD,
                    ALUSrcA, RegDst, MemtoReg, PCSrc, ALUSrcB, ALUControl, illegal};
        nhCtrl  = '{nhMemReq, nhPCWrite, nhBranch, nhIRWrite, nhRegWrite, nhMemWrite,
                    nhIorD, nhALUSrcA, nhRegDst, nhMemtoReg, nhPCSrc, nhALUSrcB,
                    {1'b0, nhALUControl}, nhIllegal};
    end

    function automatic logic functOk(input logic [5:0] f);
        return (f == 6'h20) || (f == 6'h22) || (f == 6'h24) || (f == 6'h25) || (f == 6'h2A);
    endfunction

    function automatic logic [3:0] functAlu(input logic [5:0] f);
        case (f)
            6'h20:   return 4'b0010;
            6'h22:   return 4'b0110;
            6'h24:   return 4'b0000;
            6'h25:   return 4'b0001;
            6'h2A:   return 4'b0111;
            default: return 4'b0000;
        endcase
    endfunction

    // Control outputs each step should show, straight from the step table.
    function automatic ctrl_t expectedCtrl(input state_t st, input logic rdy, input logic [5:0] f);
        ctrl_t c;
        c = '0;
        case (st)
            ST_FETCH:  begin c.memReq = 1; c.aluSrcB = 2'b01; c.aluCtl = 4'b0010;
                             c.irWrite = rdy; c.pcWrite = rdy; end
            ST_DECODE: begin c.aluSrcB = 2'b11; c.aluCtl = 4'b0010; end
            ST_MEMADR: begin c.aluSrcA = 1; c.aluSrcB = 2'b10; c.aluCtl = 4'b0010; end
            ST_MEMRD:  begin c.memReq = 1; c.iorD = 1; end
            ST_MEMWB:  begin c.regWrite = 1; c.memtoReg = 1; end
            ST_MEMWR:  begin c.memReq = 1; c.iorD = 1; c.memWrite = 1; end
            ST_EXEC:   begin c.aluSrcA = 1; c.aluCtl = functAlu(f); end
            ST_ALUWB:  begin c.regWrite = 1; c.regDst = 1; end
            ST_BRANCH: begin c.aluSrcA = 1; c.aluCtl = 4'b0110; c.branch = 1; c.pcSrc = 2'b01; end
            ST_ADDIEX: begin c.aluSrcA = 1; c.aluSrcB = 2'b10; c.aluCtl = 4'b0010; end
            ST_ADDIWB: c.regWrite = 1;
            ST_JUMP:   begin c.pcWrite = 1; c.pcSrc = 2'b10; end
            ST_TRAP:   c.illegal = 1;
            default:   c = '0;
        endcase
        return c;
    endfunction

    task automatic addWait(input state_t st, input int waits);
        for (int i = 0; i < waits; i++) seq.push_back('{st, 1'b0});
        seq.push_back('{st, 1'b1});
    endtask

    task automatic addStep(input state_t st);
        seq.push_back('{st, 1'($urandom_range(0, 1))});
    endtask

    // Expand one instruction into the steps it takes, with wait cycles.
    task automatic buildSeq(input logic [5:0] op, input logic [5:0] f, input int fw, input int mw);
        seq.delete();
        addWait(ST_FETCH, fw);
        addStep(ST_DECODE);
        case (op)
            6'h23: begin addStep(ST_MEMADR); addWait(ST_MEMRD, mw); addStep(ST_MEMWB); end
            6'h2B: begin addStep(ST_MEMADR); addWait(ST_MEMWR, mw); end
            6'h00: begin addStep(ST_EXEC); addStep(functOk(f) ? ST_ALUWB : ST_TRAP); end
            6'h04: addStep(ST_BRANCH);
            6'h08: begin addStep(ST_ADDIEX); addStep(ST_ADDIWB); end
            6'h02: addStep(ST_JUMP);
            default: addStep(ST_TRAP);
        endcase
    endtask

    task automatic playSeq(input string name, input int maxSteps);
        ctrl_t exp;
        for (int i = 0; i < seq.size() && (maxSteps < 0 || i < maxSteps); i++) begin
            @(negedge clk);
            mem_ready = seq[i].rdy;
            #1;
            checks++;
            if (state_o !== seq[i].st) begin
                errors++;
                $display("[TB] FAIL %s_state step %0d: got %0d expected %0d", name, i, state_o, seq[i].st);
            end
            exp = expectedCtrl(seq[i].st, seq[i].rdy, Funct);
            checks++;
            if (actCtrl !== exp) begin
                errors++;
                $display("[TB] FAIL %s_ctrl step %0d: got %h expected %h", name, i, actCtrl, exp);
            end
        end
    endtask

    task automatic runInstr(input string name, input logic [31:0] instr, input int fw, input int mw);
        Op    = instr[31:26];
        Funct = instr[5:0];
        buildSeq(Op, Funct, fw, mw);
        playSeq(name, -1);
    endtask

    task automatic checkTrap(input string name, input int cycles);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            mem_ready = 1'($urandom_range(0, 1));
            #1;
            checks++;
            if (state_o !== ST_TRAP || actCtrl !== expectedCtrl(ST_TRAP, 1'b0, Funct)) begin
                errors++;
                $display("[TB] FAIL %s cycle %0d: state %0d ctrl %h, expected TRAP ctrl %h",
                         name, i, state_o, actCtrl, expectedCtrl(ST_TRAP, 1'b0, Funct));
            end
        end
    endtask

    task automatic checkIdle(input string name);
        checks++;
        if (state_o !== ST_IDLE || actCtrl !== '0) begin
            errors++;
            $display("[TB] FAIL %s: state %0d ctrl %h, expected IDLE with all outputs 0",
                     name, state_o, actCtrl);
        end
        checks++;
        if (nhState !== ST_IDLE || nhCtrl !== '0) begin
            errors++;
            $display("[TB] FAIL %s_nh: state %0d ctrl %h, expected IDLE with all outputs 0",
                     name, nhState, nhCtrl);
        end
    endtask

    // Assert reset immediately (mid-cycle), check, release on the next negedge.
    task automatic doReset(input string name);
        rst = 1'b1;
        #1;
        checkIdle({name, "_assert"});
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkIdle({name, "_release"});
    endtask

    task automatic test_reset();
        rst = 1'b0; mem_ready = 1'b0; nhReady = 1'b0; Op = '0; Funct = '0;
        #2;
        doReset("reset");
    endtask

    task automatic test_lw();
        runInstr("lw", 32'h8C0A0004, 0, 0);
    endtask

    task automatic test_sw_wait();
        runInstr("sw_wait", 32'hAC0A0008, 0, 3);
    endtask

    task automatic test_rtype();
        runInstr("rtype_sub", 32'h012A4022, 0, 0);
        runInstr("rtype_bad", 32'h012A403F, 0, 0);
        checkTrap("trap_funct", 20);
        doReset("after_trap_funct");
    endtask

    task automatic test_branch_jump();
        runInstr("beq", 32'h11090003, 0, 0);
        runInstr("j", 32'h08000010, 0, 0);
    endtask

    task automatic test_fetch_wait();
        runInstr("fetch_wait", 32'h21080005, 2, 0);
    endtask

    task automatic test_back_to_back();
        logic [5:0] ops[6];
        logic [5:0] fns[5];
        logic [31:0] instr;
        ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02};
        fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
        for (int n = 0; n < 60; n++) begin
            instr = $urandom;
            instr[31:26] = ops[$urandom_range(0, 5)];
            instr[5:0]   = fns[$urandom_range(0, 4)];
            runInstr("random", instr,
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0,
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 3)) : 0);
        end
    endtask

    task automatic test_illegal_op();
        logic [5:0] op;
        do op = 6'($urandom_range(0, 63));
        while (op == 6'h23 || op == 6'h2B || op == 6'h00 || op == 6'h04 || op == 6'h08 || op == 6'h02);
        runInstr("illegal_op", {op, 26'h0000020}, 1, 0);
        checkTrap("trap_op", 5);
        doReset("after_trap_op");
    endtask

    task automatic test_reset_midwait();
        Op = 6'h2B; Funct = 6'h08;
        buildSeq(Op, Funct, 0, 3);
        playSeq("sw_midwait", 5);
        doReset("midwait");
        runInstr("post_reset_lw", 32'h8C0A0004, 0, 0);
    endtask

    task automatic test_no_handshake();
        doReset("nh_reset");
        mem_ready = 1'b0;
        nhReady   = 1'b0;
        Op = 6'h23; Funct = 6'h04;
        buildSeq(Op, Funct, 0, 0);
        for (int i = 0; i < seq.size(); i++) begin
            @(negedge clk);
            #1;
            checks++;
            if (nhState !== seq[i].st || nhCtrl !== expectedCtrl(seq[i].st, 1'b1, Funct)) begin
                errors++;
                $display("[TB] FAIL nh_lw step %0d: state %0d ctrl %h, expected state %0d ctrl %h",
                         i, nhState, nhCtrl, seq[i].st, expectedCtrl(seq[i].st, 1'b1, Funct));
            end
        end
        @(negedge clk);
        #1;
        checks++;
        if (nhState !== ST_FETCH) begin
            errors++;
            $display("[TB] FAIL nh_refetch: state %0d expected %0d", nhState, ST_FETCH);
        end
    endtask

    initial begin
        test_reset();
        test_lw();
        test_sw_wait();
        test_rtype();
        test_branch_jump();
        test_fetch_wait();
        test_back_to_back();
        test_reset_midwait();
        test_illegal_op();
        test_no_handshake();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net so a broken run can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule
